// File: rtl/tpu_top.sv
// 4x4 int8 matrix-multiply accelerator with an APB register file and three
// host/engine dual-port word memories (A, B operands and C result).
module tpu_top #(
  parameter int DWIDTH        = 8,
  parameter int MAT_MUL_SIZE  = 4,
  parameter int AWIDTH        = 10,
  parameter int MASK_WIDTH    = 4,
  parameter int REG_ADDRWIDTH = 8,
  parameter int REG_DATAWIDTH = 32
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [REG_ADDRWIDTH-1:0] PADDR,
  input  logic                     PWRITE,
  input  logic                     PSEL,
  input  logic                     PENABLE,
  input  logic [REG_DATAWIDTH-1:0] PWDATA,
  output logic [REG_DATAWIDTH-1:0] PRDATA,
  output logic                     PREADY,
  input  logic [AWIDTH-1:0]        bram_addr_a_ext,
  input  logic [31:0]              bram_wdata_a_ext,
  input  logic [MASK_WIDTH-1:0]    bram_we_a_ext,
  output logic [31:0]              bram_rdata_a_ext,
  input  logic [AWIDTH-1:0]        bram_addr_b_ext,
  input  logic [31:0]              bram_wdata_b_ext,
  input  logic [MASK_WIDTH-1:0]    bram_we_b_ext,
  output logic [31:0]              bram_rdata_b_ext,
  input  logic [AWIDTH-1:0]        bram_addr_c_ext,
  input  logic [31:0]              bram_wdata_c_ext,
  input  logic [MASK_WIDTH-1:0]    bram_we_c_ext,
  output logic [31:0]              bram_rdata_c_ext
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam int ACCW  = 20;
  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((1 << (DWIDTH - 1)) - 1);
  localparam logic signed [ACCW-1:0] SAT_MIN = -ACCW'(1 << (DWIDTH - 1));

  localparam logic [REG_ADDRWIDTH-1:0] ADDR_ENABLES = REG_ADDRWIDTH'(8'h00);
  localparam logic [REG_ADDRWIDTH-1:0] ADDR_STDN    = REG_ADDRWIDTH'(8'h04);
  localparam logic [REG_ADDRWIDTH-1:0] ADDR_MEAN    = REG_ADDRWIDTH'(8'h08);
  localparam logic [REG_ADDRWIDTH-1:0] ADDR_INV_VAR = REG_ADDRWIDTH'(8'h0C);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_ACC, S_POST, S_WRITE, S_DONE} state_e;

  state_e                     state_q;
  logic [1:0]                 cnt_q;
  logic                       eng_valid_q;
  logic [3:0]                 enables_q;
  logic [DWIDTH-1:0]          mean_q, inv_var_q;
  logic                       start_q, done_q;
  logic                       cfg_norm_q, cfg_act_q;
  logic signed [DWIDTH-1:0]   cfg_mean_q, cfg_inv_q;
  logic signed [ACCW-1:0]     acc_q [MAT_MUL_SIZE][MAT_MUL_SIZE];
  logic [REG_DATAWIDTH-1:0]   prdata_q, rd_data;

  logic [31:0]       mem_a [DEPTH];
  logic [31:0]       mem_b [DEPTH];
  logic [31:0]       mem_c [DEPTH];
  logic [31:0]       eng_a_q, eng_b_q, eng_c_wdata;
  logic [AWIDTH-1:0] eng_addr;
  logic              eng_c_we;
  logic              apb_wr, apb_rd;
  logic              unused_pwdata;

  assign PREADY        = 1'b1;
  assign PRDATA        = prdata_q;
  assign apb_wr        = PSEL & PENABLE & PWRITE;
  assign apb_rd        = PSEL & PENABLE & ~PWRITE;
  assign eng_addr      = AWIDTH'(cnt_q);
  assign eng_c_we      = (state_q == S_POST) || (state_q == S_WRITE);
  assign unused_pwdata = ^PWDATA[REG_DATAWIDTH-1:DWIDTH];

  function automatic logic signed [DWIDTH-1:0] sat(input logic signed [ACCW-1:0] x);
    if (x > SAT_MAX)      return SAT_MAX[DWIDTH-1:0];
    else if (x < SAT_MIN) return SAT_MIN[DWIDTH-1:0];
    else                  return x[DWIDTH-1:0];
  endfunction

  function automatic logic signed [ACCW-1:0] sext(input logic signed [DWIDTH-1:0] x);
    return {{(ACCW - DWIDTH){x[DWIDTH-1]}}, x};
  endfunction

  function automatic logic signed [ACCW-1:0] mul(input logic signed [DWIDTH-1:0] a,
                                                 input logic signed [DWIDTH-1:0] b);
    logic signed [2*DWIDTH-1:0] p;
    p = a * b;
    return {{(ACCW - 2 * DWIDTH){p[2*DWIDTH-1]}}, p};
  endfunction

  // The normalised product always fits in ACCW bits, so the truncated
  // product's low bits are the exact signed result.
  function automatic logic [DWIDTH-1:0] post_proc(input logic signed [ACCW-1:0] acc,
                                                  input logic norm_en, input logic act_en,
                                                  input logic signed [DWIDTH-1:0] mean,
                                                  input logic signed [DWIDTH-1:0] inv);
    logic signed [DWIDTH-1:0] v;
    logic signed [ACCW-1:0]   n;
    v = sat(acc);
    if (norm_en) begin
      n = (sext(v) - sext(mean)) * sext(inv);
      v = sat(n);
    end
    if (act_en && v[DWIDTH-1]) v = '0;
    return v;
  endfunction

  // NOTE: memory arrays have no reset branch; clearing 1024 words is neither needed nor cheap.
  always_ff @(posedge clk) begin
    for (int j = 0; j < MASK_WIDTH; j++) begin
      if (bram_we_a_ext[j]) mem_a[bram_addr_a_ext][DWIDTH*j +: DWIDTH] <= bram_wdata_a_ext[DWIDTH*j +: DWIDTH];
      if (bram_we_b_ext[j]) mem_b[bram_addr_b_ext][DWIDTH*j +: DWIDTH] <= bram_wdata_b_ext[DWIDTH*j +: DWIDTH];
      if (bram_we_c_ext[j]) mem_c[bram_addr_c_ext][DWIDTH*j +: DWIDTH] <= bram_wdata_c_ext[DWIDTH*j +: DWIDTH];
    end
    // Engine write is issued last so it overrides a colliding host write.
    if (eng_c_we) mem_c[eng_addr] <= eng_c_wdata;
    bram_rdata_a_ext <= mem_a[bram_addr_a_ext];
    bram_rdata_b_ext <= mem_b[bram_addr_b_ext];
    bram_rdata_c_ext <= mem_c[bram_addr_c_ext];
    eng_a_q          <= mem_a[eng_addr];
    eng_b_q          <= mem_b[eng_addr];
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    rd_data = '0;
    case (PADDR)
      ADDR_ENABLES: rd_data = REG_DATAWIDTH'(enables_q);
      ADDR_STDN:    rd_data = {done_q, {(REG_DATAWIDTH - 2){1'b0}}, start_q};
      ADDR_MEAN:    rd_data = REG_DATAWIDTH'(mean_q);
      ADDR_INV_VAR: rd_data = REG_DATAWIDTH'(inv_var_q);
      default:      rd_data = '0;
    endcase
  end

  always_comb begin
    eng_c_wdata = '0;
    for (int j = 0; j < MAT_MUL_SIZE; j++)
      eng_c_wdata[DWIDTH*j +: DWIDTH] = post_proc(acc_q[cnt_q][j], cfg_norm_q, cfg_act_q,
                                                  cfg_mean_q, cfg_inv_q);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      eng_valid_q <= 1'b0;
      enables_q   <= '0;
      mean_q      <= '0;
      inv_var_q   <= '0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      cfg_norm_q  <= 1'b0;
      cfg_act_q   <= 1'b0;
      cfg_mean_q  <= '0;
      cfg_inv_q   <= '0;
      prdata_q    <= '0;
      for (int i = 0; i < MAT_MUL_SIZE; i++)
        for (int j = 0; j < MAT_MUL_SIZE; j++) acc_q[i][j] <= '0;
    end else begin
      if (apb_rd) prdata_q <= rd_data;
      if (apb_wr) begin
        case (PADDR)
          ADDR_ENABLES: enables_q <= PWDATA[3:0];
          ADDR_MEAN:    mean_q    <= PWDATA[DWIDTH-1:0];
          ADDR_INV_VAR: inv_var_q <= PWDATA[DWIDTH-1:0];
          default: ;
        endcase
      end

      eng_valid_q <= (state_q == S_READ);
      if (eng_valid_q) begin
        for (int i = 0; i < MAT_MUL_SIZE; i++)
          for (int j = 0; j < MAT_MUL_SIZE; j++)
            acc_q[i][j] <= acc_q[i][j] + mul(eng_a_q[DWIDTH*i +: DWIDTH], eng_b_q[DWIDTH*j +: DWIDTH]);
      end

      case (state_q)
        S_IDLE: begin
          if (apb_wr && PADDR == ADDR_STDN) begin
            done_q  <= 1'b0;
            start_q <= PWDATA[0];
            if (PWDATA[0]) begin
              cfg_norm_q <= enables_q[1];
              cfg_act_q  <= enables_q[3];
              cfg_mean_q <= mean_q;
              cfg_inv_q  <= inv_var_q;
              cnt_q      <= '0;
              for (int i = 0; i < MAT_MUL_SIZE; i++)
                for (int j = 0; j < MAT_MUL_SIZE; j++) acc_q[i][j] <= '0;
              state_q <= enables_q[0] ? S_READ : S_DONE;
            end
          end
        end
        S_READ: begin
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_q <= S_ACC;
        end
        S_ACC: begin
          cnt_q   <= '0;
          state_q <= S_POST;
        end
        S_POST: begin
          cnt_q   <= 2'd1;
          state_q <= S_WRITE;
        end
        S_WRITE: begin
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_q <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b1;
          start_q <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_top.sv
// Self-checking bench for tpu_top: directed spec vectors plus randomized
// matrices checked against an integer matrix-product reference model.
module tb_tpu_top;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  PADDR = '0;
  logic        PWRITE = 1'b0, PSEL = 1'b0, PENABLE = 1'b0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic [9:0]  bram_addr_a_ext = '0, bram_addr_b_ext = '0, bram_addr_c_ext = '0;
  logic [31:0] bram_wdata_a_ext = '0, bram_wdata_b_ext = '0, bram_wdata_c_ext = '0;
  logic [3:0]  bram_we_a_ext = '0, bram_we_b_ext = '0, bram_we_c_ext = '0;
  logic [31:0] bram_rdata_a_ext, bram_rdata_b_ext, bram_rdata_c_ext;

  int checks = 0;
  int failures = 0;
  int a_m [4][4];
  int b_m [4][4];

  always #5 clk = ~clk;

  tpu_top dut (
    .clk(clk), .resetn(resetn),
    .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .bram_addr_a_ext(bram_addr_a_ext), .bram_wdata_a_ext(bram_wdata_a_ext),
    .bram_we_a_ext(bram_we_a_ext), .bram_rdata_a_ext(bram_rdata_a_ext),
    .bram_addr_b_ext(bram_addr_b_ext), .bram_wdata_b_ext(bram_wdata_b_ext),
    .bram_we_b_ext(bram_we_b_ext), .bram_rdata_b_ext(bram_rdata_b_ext),
    .bram_addr_c_ext(bram_addr_c_ext), .bram_wdata_c_ext(bram_wdata_c_ext),
    .bram_we_c_ext(bram_we_c_ext), .bram_rdata_c_ext(bram_rdata_c_ext)
  );

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    PADDR = a; PWDATA = d; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge clk); #1 PENABLE = 1'b1;
    @(posedge clk); #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
    PADDR = a; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge clk); #1 PENABLE = 1'b1;
    @(posedge clk); #1 PSEL = 1'b0; PENABLE = 1'b0;
    d = PRDATA;
  endtask

  task automatic mem_write(input int sel, input logic [9:0] addr, input logic [31:0] d);
    case (sel)
      0: begin bram_addr_a_ext = addr; bram_wdata_a_ext = d; bram_we_a_ext = 4'hF; end
      1: begin bram_addr_b_ext = addr; bram_wdata_b_ext = d; bram_we_b_ext = 4'hF; end
      default: begin bram_addr_c_ext = addr; bram_wdata_c_ext = d; bram_we_c_ext = 4'hF; end
    endcase
    @(posedge clk); #1;
    bram_we_a_ext = '0; bram_we_b_ext = '0; bram_we_c_ext = '0;
  endtask

  task automatic mem_read_c(input logic [9:0] addr, output logic [31:0] d);
    bram_addr_c_ext = addr;
    @(posedge clk); #1 d = bram_rdata_c_ext;
  endtask

  function automatic int clamp8(input int x);
    if (x > 127) return 127;
    if (x < -128) return -128;
    return x;
  endfunction

  // C[i][j] = sum_k A[i][k]*B[k][j], then saturate / normalise / ReLU.
  function automatic logic [31:0] model_row(input int i, input logic [3:0] en,
                                            input int mean, input int inv);
    logic [31:0] w;
    int s, v;
    w = '0;
    for (int j = 0; j < 4; j++) begin
      s = 0;
      for (int k = 0; k < 4; k++) s += a_m[i][k] * b_m[k][j];
      v = clamp8(s);
      if (en[1]) v = clamp8((v - mean) * inv);
      if (en[3] && v < 0) v = 0;
      w[8*j +: 8] = 8'(v);
    end
    return w;
  endfunction

  task automatic load_mats();
    logic [31:0] aw, bw;
    for (int k = 0; k < 4; k++) begin
      for (int e = 0; e < 4; e++) begin
        aw[8*e +: 8] = 8'(a_m[e][k]);
        bw[8*e +: 8] = 8'(b_m[k][e]);
      end
      mem_write(0, 10'(k), aw);
      mem_write(1, 10'(k), bw);
    end
  endtask

  task automatic set_directed();
    logic [31:0] aw [4];
    logic [31:0] bw [4];
    aw = '{32'h09050308, 32'h01020304, 32'h00010306, 32'h05060708};
    bw = '{32'h00030101, 32'h03040100, 32'h01030503, 32'h02030609};
    for (int k = 0; k < 4; k++)
      for (int e = 0; e < 4; e++) begin
        a_m[e][k] = int'($signed(aw[k][8*e +: 8]));
        b_m[k][e] = int'($signed(bw[k][8*e +: 8]));
      end
  endtask

  task automatic configure(input logic [3:0] en, input int mean, input int inv);
    apb_write(8'h00, 32'(en));
    apb_write(8'h08, 32'(mean));
    apb_write(8'h0C, 32'(inv));
  endtask

  task automatic run_engine(output logic [31:0] stdn, output int polls);
    bit ok;
    ok = 1'b0;
    polls = 0;
    stdn = '0;
    apb_write(8'h04, 32'h1);
    while (!ok && polls < 50) begin
      apb_read(8'h04, stdn);
      polls++;
      if (stdn[31]) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL engine_timeout: done never set after %0d polls (stdn=%08h)", polls, stdn);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    checks++;
    if (PREADY !== 1'b1) begin failures++; $display("FAIL reset_pready: got %b want 1", PREADY); end
    checks++;
    if (PRDATA !== 32'h0) begin failures++; $display("FAIL reset_prdata: got %08h want 0", PRDATA); end
    for (int r = 0; r < 4; r++) begin
      apb_read(8'(4 * r), d);
      checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL reset_reg_%02h: got %08h want 0", 4 * r, d); end
    end
  endtask

  task automatic test_regs();
    logic [31:0] d;
    apb_write(8'h00, 32'hF);
    apb_read(8'h00, d);
    checks++;
    if (d !== 32'hF) begin failures++; $display("FAIL regs_enables: got %08h want 0000000f", d); end
    apb_write(8'h14, 32'hFFFF_FFFF);
    apb_read(8'h14, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL regs_unmapped: got %08h want 0", d); end
    apb_read(8'h00, d);
    checks++;
    if (d !== 32'hF) begin failures++; $display("FAIL regs_unmapped_side: got %08h want 0000000f", d); end
    apb_read(8'h04, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL regs_stdn_idle: got %08h want 0", d); end
    apb_write(8'h08, 32'hFFFF_FF85);
    apb_read(8'h08, d);
    checks++;
    if (d !== 32'h85) begin failures++; $display("FAIL regs_mean: got %08h want 00000085", d); end
  endtask

  task automatic test_matmul(input logic [3:0] en, input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] d, stdn;
    logic [31:0] exp_c [4];
    int polls;
    exp_c = '{e0, e1, e2, e3};
    set_directed();
    load_mats();
    configure(en, 1, 1);
    run_engine(stdn, polls);
    checks++;
    if (stdn !== 32'h8000_0000) begin failures++; $display("FAIL matmul_%h_stdn: got %08h want 80000000", en, stdn); end
    for (int r = 0; r < 4; r++) begin
      mem_read_c(10'(r), d);
      checks++;
      if (d !== exp_c[r]) begin failures++; $display("FAIL matmul_%h_row%0d: got %08h want %08h", en, r, d, exp_c[r]); end
    end
  endtask

  task automatic test_saturate(input logic [3:0] en, input logic [31:0] exp_row0);
    logic [31:0] d, stdn;
    int polls;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin a_m[i][j] = 0; b_m[i][j] = 0; end
    a_m[0][0] = -128;
    b_m[0][0] = 127;
    load_mats();
    mem_write(2, 10'd0, 32'hA5A5_A5A5);
    configure(en, 0, 0);
    run_engine(stdn, polls);
    mem_read_c(10'd0, d);
    checks++;
    if (d !== exp_row0) begin failures++; $display("FAIL saturate_%h_row0: got %08h want %08h", en, d, exp_row0); end
    mem_read_c(10'd1, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL saturate_%h_row1: got %08h want 0", en, d); end
  endtask

  task automatic test_disabled();
    logic [31:0] d, stdn;
    int polls;
    for (int r = 0; r < 4; r++) mem_write(2, 10'(r), 32'h5A5A_0000 + 32'(r));
    configure(4'hE, 1, 1);
    run_engine(stdn, polls);
    checks++;
    if (polls !== 1) begin failures++; $display("FAIL disabled_latency: got %0d polls want 1", polls); end
    for (int r = 0; r < 4; r++) begin
      mem_read_c(10'(r), d);
      checks++;
      if (d !== 32'h5A5A_0000 + 32'(r)) begin
        failures++; $display("FAIL disabled_row%0d: got %08h want %08h", r, d, 32'h5A5A_0000 + 32'(r));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] d, stdn;
    logic [3:0]  en;
    int mean, inv, polls;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          a_m[i][j] = (it % 2 == 0) ? int'($urandom_range(15)) - 8 : int'($urandom_range(255)) - 128;
          b_m[i][j] = (it % 2 == 0) ? int'($urandom_range(15)) - 8 : int'($urandom_range(255)) - 128;
        end
      en   = {$urandom_range(7) == 0 ? 3'b000 : 3'($urandom_range(7)), 1'b1};
      mean = (it < 4) ? int'($urandom_range(31)) - 16 : int'($urandom_range(255)) - 128;
      inv  = (it < 4) ? int'($urandom_range(7)) - 3 : int'($urandom_range(255)) - 128;
      load_mats();
      configure(en, mean, inv);
      run_engine(stdn, polls);
      for (int r = 0; r < 4; r++) begin
        mem_read_c(10'(r), d);
        checks++;
        if (d !== model_row(r, en, mean, inv)) begin
          failures++;
          $display("FAIL random_it%0d_row%0d: got %08h want %08h (en=%h mean=%0d inv=%0d)",
                   it, r, d, model_row(r, en, mean, inv), en, mean, inv);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, stdn;
    int polls;
    set_directed();
    load_mats();
    for (int r = 0; r < 4; r++) mem_write(2, 10'(r), 32'hDEAD_BEEF);
    configure(4'hD, 1, 1);
    apb_write(8'h04, 32'h1);
    // Rows 0 and 1 land on edges 6 and 7 after the start edge.
    repeat (7) @(posedge clk);
    #1 resetn = 1'b0;
    #4 resetn = 1'b1;
    apb_read(8'h04, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL reset_mid_stdn: got %08h want 0", d); end
    mem_read_c(10'd0, d);
    checks++;
    if (d !== 32'h22525A62) begin failures++; $display("FAIL reset_mid_row0: got %08h want 22525a62", d); end
    mem_read_c(10'd3, d);
    checks++;
    if (d !== 32'hDEAD_BEEF) begin failures++; $display("FAIL reset_mid_row3: got %08h want deadbeef", d); end
    configure(4'hD, 1, 1);
    run_engine(stdn, polls);
    for (int r = 0; r < 4; r++) begin
      mem_read_c(10'(r), d);
      checks++;
      if (d !== model_row(r, 4'hD, 1, 1)) begin
        failures++; $display("FAIL restart_row%0d: got %08h want %08h", r, d, model_row(r, 4'hD, 1, 1));
      end
    end
  endtask

  initial begin
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    test_reset();
    test_regs();
    test_matmul(4'hD, 32'h22525A62, 32'h1A333F4B, 32'h132C303E, 32'h0D2E2836);
    test_matmul(4'hF, 32'h21515961, 32'h19323E4A, 32'h122B2F3D, 32'h0C2D2735);
    test_saturate(4'h9, 32'h0000_0000);
    test_saturate(4'h1, 32'h0000_0080);
    test_disabled();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tpu_top.md
Name: tpu_top

Overview:
- Small 4x4 int8 matrix-multiply accelerator configured over APB.
- Contains three internal 32-bit-word dual-port memories: A (operand), B (operand) and C (result). Each memory has one host-side external port and one engine-side port.
- The engine computes C = A x B as an outer-product accumulation, then runs optional normalization, activation and pool stages, and writes C.
- Sits under the SoC APB fabric as a memory-mapped peripheral.

Parameters:
DWIDTH, 8, element width (signed two's complement)
MAT_MUL_SIZE, 4, matrix dimension (fixed at 4 in this version)
AWIDTH, 10, word-address width of each memory (depth 1024 words)
MASK_WIDTH, 4, byte-enable width (MAT_MUL_SIZE)
REG_ADDRWIDTH, 8, APB address width
REG_DATAWIDTH, 32, APB data width

Ports:
clk  in  1  single clock for APB, engine and memories
resetn  in  1  asynchronous active-low reset
PADDR  in  REG_ADDRWIDTH  APB address
PWRITE  in  1  APB write
PSEL  in  1  APB select
PENABLE  in  1  APB enable
PWDATA  in  REG_DATAWIDTH  APB write data
PRDATA  out  REG_DATAWIDTH  APB read data
PREADY  out  1  APB ready
bram_addr_a_ext  in  AWIDTH  host word address, memory A
bram_wdata_a_ext  in  32  host write data, memory A
bram_we_a_ext  in  MASK_WIDTH  host byte write enables, memory A
bram_rdata_a_ext  out  32  host read data, memory A
bram_addr_b_ext / bram_wdata_b_ext / bram_we_b_ext / bram_rdata_b_ext  same as A, for memory B
bram_addr_c_ext / bram_wdata_c_ext / bram_we_c_ext / bram_rdata_c_ext  same as A, for memory C

Behaviour:
- Reset: all registers 0, PRDATA=0, done=0, engine idle. Memory contents are not reset.
- APB:
  - PREADY is tied to 1.
  - Writes take effect on the clk edge with PSEL&PENABLE&PWRITE.
  - Reads: PRDATA is registered on the clk edge with PSEL&PENABLE&!PWRITE and holds until the next read.
  - Unmapped reads return 0; unmapped writes are ignored.
- Registers:
  - 0x00 ENABLES [3:0]: bit0 matmul, bit1 norm, bit2 pool, bit3 activation.
  - 0x04 STDN_TPU: write bit0=1 starts the engine and clears done; write bit0=0 clears start and done. Read returns {done, 30'b0, start}.
  - 0x08 MEAN [7:0], signed.
  - 0x0C INV_VAR [7:0], signed.
- Memories:
  - Each word has byte lane j = element j. Read latency is 1 cycle on both ports; byte-enabled writes.
  - A word k = column k of A (A[0..3][k]).
  - B word k = row k of B (B[k][0..3]).
  - C word i = row i of result.
  - Simultaneous host and engine write to the same C address: engine wins.
- Engine FSM: IDLE -> READ -> ACC -> POST -> WRITE -> DONE.
  - Start edge = cycle 0.
  - Cycles 1-4: read A/B words k=0..3.
  - Cycles 2-5: acc[i][j] += A[i][k]*B[k][j], using signed 20-bit accumulators cleared at start.
  - Cycle 6: post-process.
  - Cycles 6-9: write C rows 0..3.
  - Cycle 10: done=1, start cleared, return to IDLE.
- Post-process, per element, in order:
  - Saturate to int8.
  - If norm is enabled: (x - MEAN) * INV_VAR, computed at full width, then saturated to int8.
  - If activation is enabled: ReLU (negative -> 0).
  - Pool is a pass-through in this version; the enable bit is stored only.
- If matmul is disabled at start, C is not written and done sets at cycle 1.
- A start write while busy is ignored. ENABLES, MEAN and INV_VAR are sampled at start.
- resetn assertion mid-operation aborts immediately to IDLE with done=0. A partially written C is left as-is.

Test Plan:
- Reset, then read registers 0x00-0x0C -> all 0; PREADY=1.
- Write ENABLES=0xF and read back -> PRDATA=0x0000000F. Write 0x14 and read it -> 0, with no state change.
- Load memories via the external ports: A words 0x09050308, 0x01020304, 0x00010306, 0x05060708; B words 0x00030101, 0x03040100, 0x01030503, 0x02030609. Set ENABLES=0xD, MEAN=1, INV_VAR=1, start, and poll STDN until bit31 -> C words 0x22525A62, 0x1A333F4B, 0x132C303E, 0x0D2E2836.
- Same data with ENABLES=0xF -> every byte decremented by 1 (row0 0x21515961).
- Negative data: A[0][0]=0x80 (-128), B[0][0]=0x7F, rest 0, ENABLES=0x9 -> C[0][0] saturates to -128 then ReLU gives 0x00. With ENABLES=0x1 -> 0x80.
- Assert resetn low during the WRITE state -> STDN reads 0 afterwards. A restart then completes with correct C.
